// File: rtl/control_unit_if.sv
// Control bundle between the sequencer and the single-bus datapath.
// The master side is the control unit; the slave side is the datapath.
interface control_unit_if;
    logic        stop;
    logic [31:0] IR_Data;
    logic        PC_enable;
    logic        PC_increment_enable;
    logic        IR_enable;
    logic        Y_enable;
    logic        Z_enable;
    logic        MAR_enable;
    logic        MDR_enable;
    logic        r_enable;
    logic        ram_enable;
    logic        read;
    logic        write;
    logic        Gra;
    logic        Grb;
    logic        BAout;
    logic        PC_select;
    logic        Z_LO_select;
    logic        MDR_select;
    logic        c_select;
    logic        r_select;
    logic [4:0]  alu_instruction;
    logic        run;
    logic        illegal;

    modport master (
        input  stop, IR_Data,
        output PC_enable, PC_increment_enable, IR_enable,
        output Y_enable, Z_enable, MAR_enable, MDR_enable,
        output r_enable, ram_enable, read, write,
        output Gra, Grb, BAout,
        output PC_select, Z_LO_select, MDR_select,
        output c_select, r_select,
        output alu_instruction, run, illegal
    );

    modport slave (
        output stop, IR_Data,
        input  PC_enable, PC_increment_enable, IR_enable,
        input  Y_enable, Z_enable, MAR_enable, MDR_enable,
        input  r_enable, ram_enable, read, write,
        input  Gra, Grb, BAout,
        input  PC_select, Z_LO_select, MDR_select,
        input  c_select, r_select,
        input  alu_instruction, run, illegal
    );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore sequencer: fetch T0-T2, then an opcode-specific
// execute sequence, one step per clock.
module control_unit #(
    parameter logic [4:0] ALU_ADD = 5'b00011,
    parameter logic [4:0] ALU_AND = 5'b00101,
    parameter logic [4:0] ALU_OR  = 5'b00110
) (
    input  logic            clk,
    input  logic            reset,
    control_unit_if.master  bus
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_e;

    state_e state_q, state_d;

    logic [4:0] op;
    logic is_ld, is_ldi, is_st;
    logic is_addi, is_andi, is_ori;
    logic is_nop, is_halt;
    logic is_mem, is_alu, is_ldst;
    logic unused_ir;

    assign op        = bus.IR_Data[31:27];
    assign unused_ir = ^bus.IR_Data[26:0];

    assign is_ld   = (op == 5'b00000);
    assign is_ldi  = (op == 5'b00001);
    assign is_st   = (op == 5'b00010);
    assign is_addi = (op == 5'b01100);
    assign is_andi = (op == 5'b01101);
    assign is_ori  = (op == 5'b01110);
    assign is_nop  = (op == 5'b11010);
    assign is_halt = (op == 5'b11011);
    assign is_mem  = is_ld | is_ldi | is_st;
    assign is_alu  = is_addi | is_andi | is_ori;
    assign is_ldst = is_ld | is_st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d                 = state_q;
        bus.PC_enable           = 1'b0;
        bus.PC_increment_enable = 1'b0;
        bus.IR_enable           = 1'b0;
        bus.Y_enable            = 1'b0;
        bus.Z_enable            = 1'b0;
        bus.MAR_enable          = 1'b0;
        bus.MDR_enable          = 1'b0;
        bus.r_enable            = 1'b0;
        bus.ram_enable          = 1'b0;
        bus.read                = 1'b0;
        bus.write               = 1'b0;
        bus.Gra                 = 1'b0;
        bus.Grb                 = 1'b0;
        bus.BAout               = 1'b0;
        bus.PC_select           = 1'b0;
        bus.Z_LO_select         = 1'b0;
        bus.MDR_select          = 1'b0;
        bus.c_select            = 1'b0;
        bus.r_select            = 1'b0;
        bus.alu_instruction     = 5'b0;
        bus.illegal             = 1'b0;
        bus.run = (state_q != S_RESET) && (state_q != S_HALT);

        unique case (state_q)
            S_RESET: state_d = S_T0;
            S_T0: begin
                bus.PC_select  = 1'b1;
                bus.MAR_enable = 1'b1;
                state_d = bus.stop ? S_HALT : S_T1;
            end
            S_T1: begin
                bus.PC_increment_enable = 1'b1;
                bus.read                = 1'b1;
                bus.ram_enable          = 1'b1;
                bus.MDR_enable          = 1'b1;
                state_d = S_T2;
            end
            S_T2: begin
                bus.MDR_select = 1'b1;
                bus.IR_enable  = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                unique case (1'b1)
                    is_mem: begin
                        bus.Grb      = 1'b1;
                        bus.BAout    = 1'b1;
                        bus.Y_enable = 1'b1;
                        state_d = S_T4;
                    end
                    is_alu: begin
                        bus.Grb      = 1'b1;
                        bus.r_select = 1'b1;
                        bus.Y_enable = 1'b1;
                        state_d = S_T4;
                    end
                    is_nop:  state_d = S_T0;
                    is_halt: state_d = S_HALT;
                    default: begin
                        bus.illegal = 1'b1;
                        state_d = S_T0;
                    end
                endcase
            end
            S_T4: begin
                bus.c_select = 1'b1;
                bus.Z_enable = 1'b1;
                if (is_andi)     bus.alu_instruction = ALU_AND;
                else if (is_ori) bus.alu_instruction = ALU_OR;
                else             bus.alu_instruction = ALU_ADD;
                state_d = S_T5;
            end
            S_T5: begin
                bus.Z_LO_select = 1'b1;
                if (is_ldst) begin
                    bus.MAR_enable = 1'b1;
                    state_d = S_T6;
                end else begin
                    bus.Gra      = 1'b1;
                    bus.r_enable = 1'b1;
                    state_d = S_T0;
                end
            end
            S_T6: begin
                bus.MDR_enable = 1'b1;
                if (is_ld) begin
                    bus.read       = 1'b1;
                    bus.ram_enable = 1'b1;
                end else begin
                    // st: write stays low so MDR loads from the bus
                    bus.Gra      = 1'b1;
                    bus.r_select = 1'b1;
                end
                state_d = S_T7;
            end
            S_T7: begin
                if (is_ld) begin
                    bus.MDR_select = 1'b1;
                    bus.Gra        = 1'b1;
                    bus.r_enable   = 1'b1;
                end else begin
                    bus.write      = 1'b1;
                    bus.ram_enable = 1'b1;
                end
                state_d = S_T0;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expected control words
// are queued per instruction and compared as the sequencer steps.
module tb_control_unit;

    typedef logic [25:0] vec_t;

    localparam vec_t PCE  = 26'h1 << 25;
    localparam vec_t PCI  = 26'h1 << 24;
    localparam vec_t IRE  = 26'h1 << 23;
    localparam vec_t YE   = 26'h1 << 22;
    localparam vec_t ZE   = 26'h1 << 21;
    localparam vec_t MARE = 26'h1 << 20;
    localparam vec_t MDRE = 26'h1 << 19;
    localparam vec_t RE   = 26'h1 << 18;
    localparam vec_t RAM  = 26'h1 << 17;
    localparam vec_t RD   = 26'h1 << 16;
    localparam vec_t WR   = 26'h1 << 15;
    localparam vec_t GRA  = 26'h1 << 14;
    localparam vec_t GRB  = 26'h1 << 13;
    localparam vec_t BAO  = 26'h1 << 12;
    localparam vec_t PCS  = 26'h1 << 11;
    localparam vec_t ZLO  = 26'h1 << 10;
    localparam vec_t MDRS = 26'h1 << 9;
    localparam vec_t CS   = 26'h1 << 8;
    localparam vec_t RSEL = 26'h1 << 7;
    localparam vec_t RUN  = 26'h1 << 1;
    localparam vec_t ILL  = 26'h1 << 0;
    localparam vec_t A_ADD = 26'h03 << 2;
    localparam vec_t A_AND = 26'h05 << 2;
    localparam vec_t A_OR  = 26'h06 << 2;

    localparam vec_t V_T0 = RUN | PCS | MARE;
    localparam vec_t V_T1 = RUN | PCI | RD | RAM | MDRE;
    localparam vec_t V_T2 = RUN | MDRS | IRE;
    localparam vec_t V_T3M = RUN | GRB | BAO | YE;
    localparam vec_t V_T3A = RUN | GRB | RSEL | YE;
    localparam vec_t V_T5R = RUN | ZLO | GRA | RE;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_fail;
    vec_t sb[$];

    control_unit_if bus ();

    control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t pack();
        return {bus.PC_enable, bus.PC_increment_enable, bus.IR_enable,
                bus.Y_enable, bus.Z_enable, bus.MAR_enable,
                bus.MDR_enable, bus.r_enable, bus.ram_enable,
                bus.read, bus.write, bus.Gra, bus.Grb, bus.BAout,
                bus.PC_select, bus.Z_LO_select, bus.MDR_select,
                bus.c_select, bus.r_select, bus.alu_instruction,
                bus.run, bus.illegal};
    endfunction

    task automatic check(input string tag, input vec_t exp);
        vec_t act;
        act = pack();
        n_vec++;
        assert (act === exp) else begin
            n_fail++;
            $error("FAIL %s got %h want %h", tag, act, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            check(tag, sb.pop_front());
        end
    endtask

    // Expected per-cycle control words for one instruction from T0.
    task automatic push_instr(input logic [4:0] op);
        sb.push_back(V_T0);
        sb.push_back(V_T1);
        sb.push_back(V_T2);
        case (op)
            5'b00000, 5'b00010: begin
                sb.push_back(V_T3M);
                sb.push_back(RUN | CS | ZE | A_ADD);
                sb.push_back(RUN | ZLO | MARE);
                if (op == 5'b00000) begin
                    sb.push_back(RUN | RD | RAM | MDRE);
                    sb.push_back(RUN | MDRS | GRA | RE);
                end else begin
                    sb.push_back(RUN | GRA | RSEL | MDRE);
                    sb.push_back(RUN | WR | RAM);
                end
            end
            5'b00001: begin
                sb.push_back(V_T3M);
                sb.push_back(RUN | CS | ZE | A_ADD);
                sb.push_back(V_T5R);
            end
            5'b01100, 5'b01101, 5'b01110: begin
                sb.push_back(V_T3A);
                if (op == 5'b01101)
                    sb.push_back(RUN | CS | ZE | A_AND);
                else if (op == 5'b01110)
                    sb.push_back(RUN | CS | ZE | A_OR);
                else
                    sb.push_back(RUN | CS | ZE | A_ADD);
                sb.push_back(V_T5R);
            end
            5'b11010, 5'b11011: sb.push_back(RUN);
            default:            sb.push_back(RUN | ILL);
        endcase
    endtask

    // Run n cycles from T0; IR is loaded once T0 has been sampled.
    task automatic run_cycles(input string tag, input logic [31:0] ir,
                              input int n, input int stop_at);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            pop_check(tag);
            if (i == 0) bus.IR_Data = ir;
            if (i == stop_at) bus.stop = 1'b1;
        end
    endtask

    task automatic do_instr(input string tag, input logic [31:0] ir,
                            input int n);
        push_instr(ir[31:27]);
        run_cycles(tag, ir, n, -1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset    = 1'b1;
        bus.stop = 1'b0;
        #1;
        check("reset_zero", '0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_vec       = 0;
        n_fail      = 0;
        reset       = 1'b1;
        bus.stop    = 1'b0;
        bus.IR_Data = 32'h0;
        #2;
        check("reset_init", '0);
        @(negedge clk);
        reset = 1'b0;

        do_instr("ldi",  32'h0880_0005, 6);
        do_instr("st",   32'h1100_0057, 8);
        do_instr("addi", 32'h6000_0010, 6);
        do_instr("andi", 32'h6800_00ff, 6);
        do_instr("ori",  32'h7000_0f00, 6);
        do_instr("nop",  32'hd000_0000, 4);
        do_instr("ill",  32'hf800_0000, 4);
        do_instr("ld",   32'h0000_0004, 8);

        // Reset during ld-T6: outputs must drop without waiting a clock.
        push_instr(5'b00000);
        run_cycles("ld_rst", 32'h0000_0004, 7, -1);
        sb.delete();
        reset = 1'b1;
        #1;
        check("rst_mid_ld", '0);
        @(negedge clk);
        reset    = 1'b0;
        bus.stop = 1'b0;
        @(posedge clk);
        #1;
        check("rst_to_t0", V_T0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_at_t0", '0);
        @(negedge clk);
        reset = 1'b0;

        // stop raised in ld-T2 takes effect at the following T0.
        push_instr(5'b00000);
        sb.push_back(V_T0);
        sb.push_back('0);
        sb.push_back('0);
        sb.push_back('0);
        run_cycles("ld_stop", 32'h0000_0004, 12, 2);

        apply_reset();
        push_instr(5'b11011);
        for (int i = 0; i < 20; i++) sb.push_back('0);
        run_cycles("halt", 32'hd800_0000, 24, -1);

        apply_reset();
        do_instr("after_halt", 32'h0880_0001, 6);

        if (sb.size() != 0) begin
            n_fail++;
            $error("FAIL leftover got %0d want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_fail);
        $finish;
    end

endmodule
